// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester-side handshakes and ALU-side operand/result wires for alu_share_arbiter.
// The arbiter uses the slave modport; requesters and the ALU model sit on the master side.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_srcA;
  logic [2*WIDTH-1:0] req_srcB;
  logic [2*OPW-1:0]   req_op;
  logic [1:0]         rsp_valid;
  logic [1:0]         rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_zero;
  logic               rsp_err;
  logic [WIDTH-1:0]   alu_SrcA;
  logic [WIDTH-1:0]   alu_SrcB;
  logic [OPW-1:0]     alu_aluControl;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_zero;
  logic [1:0]         arb_state;

  modport slave (
    input  req_valid, req_srcA, req_srcB, req_op, rsp_ready, alu_result, alu_zero,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err,
           alu_SrcA, alu_SrcB, alu_aluControl, arb_state
  );

  modport master (
    output req_valid, req_srcA, req_srcB, req_op, rsp_ready, alu_result, alu_zero,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err,
           alu_SrcA, alu_SrcB, alu_aluControl, arb_state
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between the integer core (port 0) and the CHERI unit (port 1).
// Optional illegal-op checking is enabled by defining ALU_ARB_OPCHECK_EN.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  // Handshakes: a transfer happens on a port in any cycle where its valid and ready
  // are both high at the rising edge; requesters hold valid/operands until ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             rr;
  logic             owner;
  logic             win;
  logic             grant;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [OPW-1:0]   opc;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic [1:0]       rsp_valid_q;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OPW-1:0]   sel_op;
`ifdef ALU_ARB_OPCHECK_EN
  logic             op_illegal;
  logic             err_q;
  logic             err_rsp;
`endif

  always_comb begin
    win    = (&bus.req_valid) ? rr : bus.req_valid[1];
    grant  = (state == IDLE) && (|bus.req_valid);
    sel_a  = win ? bus.req_srcA[2*WIDTH-1:WIDTH] : bus.req_srcA[WIDTH-1:0];
    sel_b  = win ? bus.req_srcB[2*WIDTH-1:WIDTH] : bus.req_srcB[WIDTH-1:0];
    sel_op = win ? bus.req_op[2*OPW-1:OPW]       : bus.req_op[OPW-1:0];
  end

`ifdef ALU_ARB_OPCHECK_EN
  // Only ADD, SUB, AND, OR, XOR (codes 0-4) are legal.
  always_comb begin
    op_illegal = (sel_op > OPW'(4));
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr          <= 1'b0;
      owner       <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      opc         <= '0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
`ifdef ALU_ARB_OPCHECK_EN
      err_q       <= 1'b0;
      err_rsp     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            opa   <= sel_a;
            opb   <= sel_b;
            opc   <= sel_op;
            owner <= win;
            rr    <= ~win;
`ifdef ALU_ARB_OPCHECK_EN
            err_q <= op_illegal;
`endif
            state <= EXEC;
          end
        end
        EXEC: begin
`ifdef ALU_ARB_OPCHECK_EN
          // The ALU still runs for an illegal op; its output is simply dropped.
          if (err_q) begin
            res_q  <= '0;
            zero_q <= 1'b1;
          end else begin
            res_q  <= bus.alu_result;
            zero_q <= bus.alu_zero;
          end
          err_rsp <= err_q;
`else
          res_q  <= bus.alu_result;
          zero_q <= bus.alu_zero;
`endif
          rsp_valid_q <= owner ? 2'b10 : 2'b01;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[owner]) begin
            rsp_valid_q <= 2'b00;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_result     = res_q;
  assign bus.rsp_zero       = zero_q;
  assign bus.alu_SrcA       = opa;
  assign bus.alu_SrcB       = opb;
  assign bus.alu_aluControl = opc;
  assign bus.arb_state      = state;
`ifdef ALU_ARB_OPCHECK_EN
  assign bus.rsp_err        = err_rsp;
`else
  assign bus.rsp_err        = 1'b0;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 32-bit ALU datapath between two requesters: port 0 is the integer core, port 1 is the CHERI capability/bounds unit.
- Round-robin arbitration with valid/ready handshakes on both sides; only one transaction is in flight at a time.
- Drives the ALU operand and control inputs from registered operands and captures ALU result/Zero into a response register.
- Sits between the requesters and the ALU instance in the execute stage.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU data width.
- OPW, 4, ALU control width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_srcA  in  2*WIDTH  operand A; requester i in slice [i*WIDTH +: WIDTH].
- req_srcB  in  2*WIDTH  operand B, same packing.
- req_op  in  2*OPW  ALU control code per requester.
- rsp_valid  out  2  per-requester response valid; at most one bit high.
- rsp_ready  in  2  per-requester response accept.
- rsp_result  out  WIDTH  result, shared bus; qualified by rsp_valid.
- rsp_zero  out  1  ALU Zero flag for the result.
- rsp_err  out  1  illegal-op flag; see Optional Feature.
- alu_SrcA  out  WIDTH  to ALU SrcA.
- alu_SrcB  out  WIDTH  to ALU SrcB.
- alu_aluControl  out  OPW  to ALU aluControl.
- alu_result  in  WIDTH  from ALU ALUresult.
- alu_zero  in  1  from ALU Zero.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset clears all registers immediately. Outputs go low: req_ready=0, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, alu_* = 0. State is IDLE, and the rr pointer is 0, so requester 0 wins the first tie.
- IDLE:
  - req_ready is combinational: winner = the only valid requester; on a tie, the requester given by the rr pointer.
  - On req_valid[w] && req_ready[w]: latch srcA, srcB and op of w, plus owner=w. Set rr pointer to ~w and go to EXEC.
  - No valid requests: stay in IDLE.
- EXEC (1 cycle):
  - alu_* are driven from the operand registers only; they are stable for the whole cycle.
  - At the clock edge, capture alu_result into rsp_result and alu_zero into rsp_zero, then go to RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_result, rsp_zero and rsp_err are held stable.
  - On rsp_ready[owner]: clear rsp_valid and go to IDLE.
  - rsp_ready of the non-owner is ignored. req_ready=0 for the whole of EXEC and RESP.
- Latency: request handshake at cycle N gives rsp_valid at N+2. With rsp_ready held high, back-to-back throughput is one op per 3 cycles.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- Requesters must hold valid and operands stable until ready. The block samples them only in the handshake cycle.
- Simultaneous events: a new request arriving during EXEC/RESP waits and is not dropped. rsp_ready asserted before rsp_valid has no effect.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is issued, and the block returns to the reset state.
- alu_* hold their last value in IDLE and RESP; they change only on a grant.

Optional Feature:
- Macro ALU_ARB_OPCHECK_EN.
- Defined:
  - Ops 0-4 (ADD, SUB, AND, OR, XOR) are legal.
  - Any other op latches err=1 at grant; in RESP, rsp_err=1, rsp_result=0, rsp_zero=1.
  - The ALU is still sequenced, but its result is discarded.
- Undefined: no op decoding, rsp_err tied to 0, and the ALU default result is passed through.

Test Plan:
- Single op: reset, then port0 op=0 (ADD), A=5, B=7, rsp_ready=1 -> req_ready[0] in the same cycle; rsp_valid[0] two cycles later with result 12, zero=0; back to IDLE the cycle after.
- Zero flag: port1 op=1 (SUB), A=B=0x1234 -> rsp_valid[1], result 0, zero=1; rsp_valid[0] stays 0 throughout.
- Round-robin: both ports valid continuously, 4 ops each -> grant order 0,1,0,1,...; each result routed to the correct rsp_valid bit; no starvation.
- Backpressure: port0 op=2 (AND), A=0xF0F0, B=0xFF00, rsp_ready[0]=0 for 5 cycles while port1 is valid -> result 0xF000 held stable, req_ready=00 throughout; port1 granted only after rsp_ready[0] goes high.
- Reset mid-op: assert rst_n=0 during EXEC -> all outputs 0 immediately; after release, no stale rsp_valid, and the next tie is won by port0.
- Option: with ALU_ARB_OPCHECK_EN, op=4'b1010 -> rsp_err=1, result 0, zero=1; without it, rsp_err=0 and result 0.
